// File: rtl/peak_decimator_pkg.sv
// Shared constants and types for the peak decimator.
//   NUM_CH / SAMPLES_PER_CH / SAMPLE_W / DATA_W : ADC word geometry
//   CH_A..CH_D                                  : channel index constants
//   state_t                                     : window-control state encoding
package peak_decimator_pkg;

  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned SAMPLE_W       = 8;
  localparam int unsigned SAMPLES_PER_CH = 4;
  localparam int unsigned DATA_W         = 128;

  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_C = 2;
  localparam int unsigned CH_D = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/peak_lane_reduce.sv
// Combinational max/min of one channel's samples (two-level compare tree).
//   samples  : SAMPLES_PER_CH unsigned samples of one channel
//   lane_max : largest sample
//   lane_min : smallest sample
module peak_lane_reduce
  import peak_decimator_pkg::*;
(
  input  logic [SAMPLES_PER_CH-1:0][SAMPLE_W-1:0] samples,
  output logic [SAMPLE_W-1:0]                     lane_max,
  output logic [SAMPLE_W-1:0]                     lane_min
);

  logic [SAMPLE_W-1:0] max_lo;
  logic [SAMPLE_W-1:0] max_hi;
  logic [SAMPLE_W-1:0] min_lo;
  logic [SAMPLE_W-1:0] min_hi;

  always_comb begin
    max_lo   = (samples[0] > samples[1]) ? samples[0] : samples[1];
    min_lo   = (samples[0] < samples[1]) ? samples[0] : samples[1];
    max_hi   = (samples[2] > samples[3]) ? samples[2] : samples[3];
    min_hi   = (samples[2] < samples[3]) ? samples[2] : samples[3];
    lane_max = (max_lo > max_hi) ? max_lo : max_hi;
    lane_min = (min_lo < min_hi) ? min_lo : min_hi;
  end

endmodule

// File: rtl/peak_decimator.sv
// Windowed per-channel peak (max/min) decimator for a 4-channel ADC stream.
//   rxclk, scan_rst : clock, async active-low reset
//   rxdata, rxvalid : 128-bit ADC word (byte k -> channel k mod 4) and qualifier
//   div_n           : window length in accepted words (0 treated as 1)
//   hold            : blocks new accepts; in-flight words still complete
//   ch*_max/ch*_min : per-channel window results, held between strobes
//   enout           : one-cycle result strobe, 2 cycles after the closing accept
//   win_cnt         : saturating count of completed windows
module peak_decimator
  import peak_decimator_pkg::*;
(
  input  logic              rxclk,
  input  logic              scan_rst,
  input  logic [DATA_W-1:0] rxdata,
  input  logic              rxvalid,
  input  logic [31:0]       div_n,
  input  logic              hold,
  output logic [7:0]        cha_max,
  output logic [7:0]        cha_min,
  output logic [7:0]        chb_max,
  output logic [7:0]        chb_min,
  output logic [7:0]        chc_max,
  output logic [7:0]        chc_min,
  output logic [7:0]        chd_max,
  output logic [7:0]        chd_min,
  output logic              enout,
  output logic [31:0]       win_cnt
);

  typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_vec_t;

  state_t state_q, state_d;

  logic        accept;
  logic        first_acc;
  logic        close_acc;
  logic [31:0] n_eff;
  logic [31:0] n_cur;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] n_q, n_d;

  logic [NUM_CH-1:0][SAMPLES_PER_CH-1:0][SAMPLE_W-1:0] lane_in;
  ch_vec_t lane_max;
  ch_vec_t lane_min;

  logic    s1_vld_q, s1_vld_d;
  logic    s1_first_q, s1_first_d;
  logic    s1_last_q, s1_last_d;
  ch_vec_t s1_max_q, s1_max_d;
  ch_vec_t s1_min_q, s1_min_d;

  ch_vec_t fold_max;
  ch_vec_t fold_min;
  ch_vec_t acc_max_q, acc_max_d;
  ch_vec_t acc_min_q, acc_min_d;
  ch_vec_t res_max_q, res_max_d;
  ch_vec_t res_min_q, res_min_d;
  logic        enout_q, enout_d;
  logic [31:0] win_cnt_q, win_cnt_d;

  assign accept = rxvalid & ~hold;

  // ---------------- window FSM ----------------
  always_ff @(posedge rxclk or negedge scan_rst) begin
    if (!scan_rst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // An accept that also closes the window goes straight to FLUSH (covers N=1).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = close_acc ? ST_FLUSH : ST_ACCUM;
      ST_ACCUM: if (close_acc) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!accept)        state_d = ST_IDLE;
        else if (close_acc) state_d = ST_FLUSH;
        else                state_d = ST_ACCUM;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outside ACCUM the word counter is always 0, so any accept opens a window.
  always_comb begin
    first_acc = accept && (state_q != ST_ACCUM);
  end

  // ---------------- window length / word counter ----------------
  always_comb begin
    n_eff     = (div_n == '0) ? 32'd1 : div_n;
    n_cur     = first_acc ? n_eff : n_q;
    // cnt_q never exceeds n_cur-1, so this compare cannot wrap at N=0xFFFFFFFF.
    close_acc = accept && (cnt_q == n_cur - 32'd1);
    n_d       = n_cur;
    cnt_d     = cnt_q;
    if (accept) cnt_d = close_acc ? '0 : cnt_q + 32'd1;
  end

  // ---------------- stage 1: per-lane reduction ----------------
  always_comb begin
    lane_in = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned j = 0; j < SAMPLES_PER_CH; j++) begin
        lane_in[c][j] = rxdata[(j*NUM_CH + c)*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    peak_lane_reduce u_reduce (
      .samples  (lane_in[c]),
      .lane_max (lane_max[c]),
      .lane_min (lane_min[c])
    );
  end

  always_comb begin
    s1_vld_d   = accept;
    s1_first_d = first_acc;
    s1_last_d  = close_acc;
    s1_max_d   = accept ? lane_max : s1_max_q;
    s1_min_d   = accept ? lane_min : s1_min_q;
  end

  // ---------------- stage 2: accumulate and publish ----------------
  // Results load from the fold value in the same edge as the accumulators,
  // which is what keeps the closing accept -> enout latency at 2.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (s1_first_q) begin
        fold_max[c] = s1_max_q[c];
        fold_min[c] = s1_min_q[c];
      end else begin
        fold_max[c] = (s1_max_q[c] > acc_max_q[c]) ? s1_max_q[c] : acc_max_q[c];
        fold_min[c] = (s1_min_q[c] < acc_min_q[c]) ? s1_min_q[c] : acc_min_q[c];
      end
    end

    acc_max_d = s1_vld_q ? fold_max : acc_max_q;
    acc_min_d = s1_vld_q ? fold_min : acc_min_q;
    enout_d   = s1_vld_q && s1_last_q;
    res_max_d = enout_d ? fold_max : res_max_q;
    res_min_d = enout_d ? fold_min : res_min_q;
    win_cnt_d = win_cnt_q;
    if (enout_d && (win_cnt_q != '1)) win_cnt_d = win_cnt_q + 32'd1;
  end

  always_ff @(posedge rxclk or negedge scan_rst) begin
    if (!scan_rst) begin
      cnt_q      <= '0;
      n_q        <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_max_q   <= '0;
      s1_min_q   <= '0;
      acc_max_q  <= '0;
      acc_min_q  <= '0;
      res_max_q  <= '0;
      res_min_q  <= '0;
      enout_q    <= 1'b0;
      win_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_max_q   <= s1_max_d;
      s1_min_q   <= s1_min_d;
      acc_max_q  <= acc_max_d;
      acc_min_q  <= acc_min_d;
      res_max_q  <= res_max_d;
      res_min_q  <= res_min_d;
      enout_q    <= enout_d;
      win_cnt_q  <= win_cnt_d;
    end
  end

  assign cha_max = res_max_q[CH_A];
  assign cha_min = res_min_q[CH_A];
  assign chb_max = res_max_q[CH_B];
  assign chb_min = res_min_q[CH_B];
  assign chc_max = res_max_q[CH_C];
  assign chc_min = res_min_q[CH_C];
  assign chd_max = res_max_q[CH_D];
  assign chd_min = res_min_q[CH_D];
  assign enout   = enout_q;
  assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_peak_decimator.sv
// Directed bench for peak_decimator: a table of single-word windows applied
// back-to-back (N=1 and N=0), plus hand-written multi-cycle sequences.
module tb_peak_decimator;

  logic         rxclk    = 1'b0;
  logic         scan_rst = 1'b0;
  logic [127:0] rxdata   = '0;
  logic         rxvalid  = 1'b0;
  logic [31:0]  div_n    = 32'd1;
  logic         hold     = 1'b0;
  logic [7:0]   cha_max, cha_min, chb_max, chb_min;
  logic [7:0]   chc_max, chc_min, chd_max, chd_min;
  logic         enout;
  logic [31:0]  win_cnt;

  peak_decimator dut (
    .rxclk   (rxclk),
    .scan_rst(scan_rst),
    .rxdata  (rxdata),
    .rxvalid (rxvalid),
    .div_n   (div_n),
    .hold    (hold),
    .cha_max (cha_max),
    .cha_min (cha_min),
    .chb_max (chb_max),
    .chb_min (chb_min),
    .chc_max (chc_max),
    .chc_min (chc_min),
    .chd_max (chd_max),
    .chd_min (chd_min),
    .enout   (enout),
    .win_cnt (win_cnt)
  );

  always #5 rxclk = ~rxclk;

  int cyc = 0;
  always @(posedge rxclk) cyc <= cyc + 1;

  // enout event log: cycle index and {max,min} of channels A and B
  int          ev_cyc[$];
  logic [15:0] ev_a[$];
  logic [15:0] ev_b[$];
  always @(negedge rxclk) begin
    if (enout === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_a.push_back({cha_max, cha_min});
      ev_b.push_back({chb_max, chb_min});
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // [channel][sample]
  typedef logic [3:0][3:0][7:0] smp_t;

  // Each argument lists one channel's samples 0..3 left to right.
  function automatic smp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
    smp_t s;
    for (int j = 0; j < 4; j++) begin
      s[0][j] = a[31-8*j -: 8];
      s[1][j] = b[31-8*j -: 8];
      s[2][j] = c[31-8*j -: 8];
      s[3][j] = d[31-8*j -: 8];
    end
    return s;
  endfunction

  function automatic smp_t mk_all(input logic [7:0] k);
    return mk({4{k}}, {4{k}}, {4{k}}, {4{k}});
  endfunction

  function automatic logic [127:0] pack(input smp_t s);
    logic [127:0] w;
    w = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        w[8*(4*j+c) +: 8] = s[c][j];
    return w;
  endfunction

  typedef struct {
    smp_t        s;
    logic [31:0] emax;  // {A,B,C,D}
    logic [31:0] emin;
  } vec_t;
  vec_t vt[4];

  int last_acc;

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic acc(input smp_t s);
    rxvalid  = 1'b1;
    rxdata   = pack(s);
    last_acc = cyc;
    tick();
    rxvalid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    scan_rst = 1'b0;
    rxvalid  = 1'b0;
    hold     = 1'b0;
    #2;
    chk("rst_max", {cha_max, chb_max, chc_max, chd_max}, 32'h0);
    chk("rst_min", {cha_min, chb_min, chc_min, chd_min}, 32'h0);
    chk("rst_enout", enout, 0);
    chk("rst_win_cnt", win_cnt, 0);
    tick();
    tick();
    scan_rst = 1'b1;
    ev_cyc.delete();
    ev_a.delete();
    ev_b.delete();
    tick();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        rxvalid = 1'b1;
        rxdata  = pack(vt[i].s);
      end else begin
        rxvalid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("%s_v%0d_enout", tag, i-1), enout, 1);
        chk($sformatf("%s_v%0d_max", tag, i-1), {cha_max, chb_max, chc_max, chd_max}, vt[i-1].emax);
        chk($sformatf("%s_v%0d_min", tag, i-1), {cha_min, chb_min, chc_min, chd_min}, vt[i-1].emin);
        chk($sformatf("%s_v%0d_win_cnt", tag, i-1), win_cnt, i);
      end
    end
    tick();
    chk($sformatf("%s_enout_low", tag), enout, 0);
  endtask

  task automatic chk_events(input string tag, input int n, input int cyc_exp[3],
                            input logic [15:0] a_exp[3]);
    chk($sformatf("%s_enout_count", tag), ev_cyc.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ev_cyc.size()) begin
        chk($sformatf("%s_ev%0d_cycle", tag, i), ev_cyc[i], cyc_exp[i]);
        chk($sformatf("%s_ev%0d_chA", tag, i), ev_a[i], a_exp[i]);
      end
    end
  endtask

  initial begin
    int          ce[3];
    logic [15:0] ae[3];

    vt[0].s = mk(32'h1080057F, 32'h00000000, 32'hFFFFFFFF, 32'h01020304);
    vt[0].emax = 32'h8000FF04; vt[0].emin = 32'h0500FF01;
    vt[1].s = mk(32'hFF00807F, 32'h12345678, 32'h817F8001, 32'hAAAAAAAB);
    vt[1].emax = 32'hFF7881AB; vt[1].emin = 32'h001201AA;
    vt[2].s = mk(32'h55555555, 32'hFE01FF02, 32'h00100020, 32'hC03F8040);
    vt[2].emax = 32'h55FF20C0; vt[2].emin = 32'h5501003F;
    vt[3].s = mk(32'h01000203, 32'h80807F81, 32'h33442211, 32'hFFFEFD00);
    vt[3].emax = 32'h038144FF; vt[3].emin = 32'h007F1100;

    // N=1 back-to-back, then div_n=0 behaving as N=1
    do_reset();
    div_n = 32'd1;
    run_table("n1");
    do_reset();
    div_n = 32'd0;
    run_table("n0");

    // N=4: channel B peak in word 2, trough in word 3
    do_reset();
    div_n = 32'd4;
    acc(mk(32'h01010101, 32'h40506070, 32'h01010101, 32'h01010101));
    acc(mk(32'h02020202, 32'h41424344, 32'h02020202, 32'h02020202));
    acc(mk(32'h03030303, 32'h10FF2030, 32'h03030303, 32'h03030303));
    acc(mk(32'h04040404, 32'h20009030, 32'h04040404, 32'h04040404));
    ce[0] = last_acc + 2; ae[0] = 16'h0401;
    idle(4);
    chk_events("n4", 1, ce, ae);
    chk("n4_chb_max", chb_max, 8'hFF);
    chk("n4_chb_min", chb_min, 8'h00);
    chk("n4_win_cnt", win_cnt, 1);

    // N=3 with rxvalid 1,0,1,0,1; gap data would disturb A and B
    do_reset();
    div_n = 32'd3;
    acc(mk(32'h20304050, 32'h11111111, 32'h0, 32'h0));
    rxdata = pack(mk(32'hFFFF0000, 32'hFF0000FF, 32'hFFFFFFFF, 32'h0));
    tick();
    acc(mk(32'h25603545, 32'h11111111, 32'h0, 32'h0));
    rxdata = pack(mk(32'h00FF00FF, 32'h00FF00FF, 32'hFFFFFFFF, 32'h0));
    tick();
    acc(mk(32'h22334455, 32'h11111111, 32'h0, 32'h0));
    ce[0] = last_acc + 2; ae[0] = 16'h6020;
    idle(4);
    chk_events("gap", 1, ce, ae);
    chk("gap_chb", {chb_max, chb_min}, 16'h1111);

    // hold mid-window, then hold right after the closing accept
    do_reset();
    div_n = 32'd2;
    acc(mk_all(8'h01));
    hold = 1'b1; rxvalid = 1'b1; rxdata = pack(mk_all(8'hFF));
    idle(3);
    hold = 1'b0;
    acc(mk_all(8'h02));
    ce[0] = last_acc + 2; ae[0] = 16'h0201;
    hold = 1'b1; rxvalid = 1'b1; rxdata = pack(mk_all(8'h00));
    idle(5);
    hold = 1'b0; rxvalid = 1'b0;
    chk_events("hold", 1, ce, ae);
    chk("hold_win_cnt", win_cnt, 1);

    // N=8, div_n changed to 2 after the 3rd accept
    do_reset();
    div_n = 32'd8;
    for (int k = 1; k <= 12; k++) begin
      acc(mk_all(8'(k)));
      if (k == 3) div_n = 32'd2;
      if (k == 8)  ce[0] = last_acc + 2;
      if (k == 10) ce[1] = last_acc + 2;
      if (k == 12) ce[2] = last_acc + 2;
    end
    ae[0] = 16'h0801; ae[1] = 16'h0A09; ae[2] = 16'h0C0B;
    idle(4);
    chk_events("ndiv", 3, ce, ae);
    chk("ndiv_win_cnt", win_cnt, 3);

    // reset after 5 of 8 accepts, then a clean window of 8
    do_reset();
    div_n = 32'd8;
    repeat (5) acc(mk(32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00));
    chk("prerst_enout_count", ev_cyc.size(), 0);
    do_reset();
    for (int k = 1; k <= 8; k++) acc(mk_all(8'(k)));
    ce[0] = last_acc + 2; ae[0] = 16'h0801;
    idle(4);
    chk_events("postrst", 1, ce, ae);
    chk("postrst_chb", ev_b.size() > 0 ? {16'h0, ev_b[0]} : 32'hDEAD, 32'h0801);
    chk("postrst_win_cnt", win_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
